// File: rtl/add_saturate_acc.sv
// Multi-lane saturating add/sub accumulator with frame framing and a registered, back-pressured result.
// Optional macro ADD_SATURATE_ACC_SAT_FLAG_EN builds per-lane sticky saturation flags on out_sat.
module add_saturate_acc #(
   parameter int unsigned N = 8,
   parameter int unsigned L = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_first,
   input  logic             in_last,
   input  logic             in_sub,
   input  logic [L*N-1:0]   in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [L*N-1:0]   out_data,
   output logic [L-1:0]     out_sat,
   output logic             proto_err
);

   localparam int unsigned W = L * N;

   typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   acc_q, acc_d;
   logic [W-1:0]   out_data_d;
   logic           out_valid_d;
   logic           proto_err_d;
   logic [W-1:0]   step_res;
   logic [N:0]     lane_t;
   logic           accept;
   logic           restart;

   // N+1-bit sign-extended add or subtract of one lane
   function automatic logic [N:0] lane_sum(input logic [N-1:0] a, input logic [N-1:0] x,
                                           input logic sub);
      logic [N:0] ae;
      logic [N:0] xe;
      ae = {a[N-1], a};
      xe = {x[N-1], x};
      return sub ? (ae - xe) : (ae + xe);
   endfunction

   // Top two bits disagreeing means the true result left the N-bit range
   function automatic logic [N-1:0] clamp(input logic [N:0] t);
      case (t[N -: 2])
         2'b01:   return {1'b0, {(N-1){1'b1}}};
         2'b10:   return {1'b1, {(N-1){1'b0}}};
         default: return t[N-1:0];
      endcase
   endfunction

   assign in_ready = ~out_valid | out_ready;
   assign accept   = in_valid & in_ready;
   // Any beat outside an open frame, or a first beat, starts from zero
   assign restart  = (state_q == IDLE) | in_first;

`ifdef ADD_SATURATE_ACC_SAT_FLAG_EN
   logic [L-1:0] sticky_q, sticky_d, step_stk;
   logic [L-1:0] sat_q, sat_d;
   assign out_sat = sat_q;
`else
   assign out_sat = '0;
`endif

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      out_data_d  = out_data;
      out_valid_d = out_valid;
      proto_err_d = proto_err;
      step_res    = '0;
      lane_t      = '0;
`ifdef ADD_SATURATE_ACC_SAT_FLAG_EN
      sticky_d    = sticky_q;
      sat_d       = sat_q;
      step_stk    = '0;
`endif

      for (int unsigned k = 0; k < L; k++) begin
         lane_t = lane_sum(restart ? N'(0) : acc_q[k*N +: N], in_data[k*N +: N], in_sub);
         step_res[k*N +: N] = clamp(lane_t);
`ifdef ADD_SATURATE_ACC_SAT_FLAG_EN
         step_stk[k] = (~restart & sticky_q[k]) | (lane_t[N] ^ lane_t[N-1]);
`endif
      end

      if (out_valid & out_ready)
         out_valid_d = 1'b0;

      if (accept) begin
         if ((state_q == IDLE) != in_first)
            proto_err_d = 1'b1;
         if (in_last) begin
            out_valid_d = 1'b1;
            out_data_d  = step_res;
            state_d     = IDLE;
`ifdef ADD_SATURATE_ACC_SAT_FLAG_EN
            sat_d       = step_stk;
`endif
         end else begin
            acc_d       = step_res;
            state_d     = ACCUM;
`ifdef ADD_SATURATE_ACC_SAT_FLAG_EN
            sticky_d    = step_stk;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         proto_err <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         out_valid <= out_valid_d;
         out_data  <= out_data_d;
         proto_err <= proto_err_d;
      end
   end

`ifdef ADD_SATURATE_ACC_SAT_FLAG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= '0;
         sat_q    <= '0;
      end else begin
         sticky_q <= sticky_d;
         sat_q    <= sat_d;
      end
   end
`endif

endmodule

// File: doc/add_saturate_acc.md
# add_saturate_acc

Multi-lane pipelined saturating accumulator for LLR message sums in the LDPC decoder's variable-node path. It accepts a frame of beats, each carrying L signed N-bit lanes, and adds or subtracts each beat into a per-lane accumulator. The accumulator clamps to the two's-complement range after every step. At frame end it emits one registered result with valid/ready back-pressure.

## Interface
- N, 8, lane width in bits (two's complement), N >= 2
- L, 4, number of parallel lanes, L >= 1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_first  in  1  beat opens a new frame
- in_last  in  1  beat closes the frame
- in_sub  in  1  1: acc − x, 0: acc + x (applies to all lanes of the beat)
- in_data  in  L*N  lane k at bits [k*N +: N]
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- out_data  out  L*N  saturated per-lane sums, same packing as in_data
- out_sat  out  L  per-lane flag: saturation occurred at least once in the frame
- proto_err  out  1  sticky protocol error flag; cleared only by reset

## Operation
- Beat accepted when in_valid & in_ready.
- Each step uses N+1-bit sign-extended arithmetic: t = {a[N-1],a} ± {x[N-1],x}.
  - If the top two bits of t are 01, the result is 2^(N-1)−1.
  - If they are 10, the result is −2^(N-1).
  - Otherwise the result is t[N-1:0].
  - Subtracting −2^(N-1) from 0 therefore yields +2^(N-1)−1 and counts as saturation.
- FSM states: IDLE (no open frame) and ACCUM (frame open).
  - IDLE with an accepted beat: operand a = 0. If in_first is 0, set proto_err and process the beat as a first beat.
  - ACCUM with an accepted beat and in_first = 1: set proto_err, discard the partial sums, restart with a = 0.
  - ACCUM with an accepted beat and in_first = 0: a = current accumulator.
  - Accepted beat with in_last = 1: load out_data/out_sat from that beat's results, set out_valid, go to IDLE. Otherwise store the results in the accumulator and go to (or stay in) ACCUM.
  - A single-beat frame (first & last) is legal.
- Output register: out_valid clears on out_valid & out_ready unless a new last-beat loads in the same cycle.
- in_ready = ~out_valid | out_ready. The block stalls all input while the result is unconsumed, including non-last beats.

## Timing
- Reset: in_ready = 1; out_valid = 0; out_data = 0; out_sat = 0; proto_err = 0; accumulators = 0; state IDLE.
- Reset asserted mid-frame or while out_valid = 1 drops the frame and the result, with no output.
- Latency: last beat accepted at edge t → out_valid = 1 and data valid after edge t; visible in cycle t+1.
- Throughput: one beat per cycle, and back-to-back frames with no bubble when out_ready = 1.
- Simultaneous output handshake and new last beat: out_data is replaced by the new result; out_valid stays 1.
- out_data and out_sat are stable while out_valid & ~out_ready.
- in_ready has a combinational path from out_ready only; there is no path from in_valid.

## Configuration
- Macro: ADD_SATURATE_ACC_SAT_FLAG_EN.
- Defined:
  - Per-lane sticky saturation tracking is built.
  - The sticky bit clears at each frame's first beat and is ORed with each step's clamp.
  - out_sat carries the final value with the result.
- Undefined: tracking logic is removed and out_sat is tied to 0. All other behaviour is unchanged.

## Test plan
- N=8, L=4; one frame of 3 add beats with lane 0 = 10, 20, 30 and out_ready = 1 → out_data lane 0 = 60, out_valid one cycle after the last beat, out_sat = 0.
- Lane 1 adds 100 then 100 → 127, out_sat[1] = 1 (flag build). Lane 2 adds −100, −100 → −128. Lane 3 with in_sub = 1 and x = −128 from 0 → 127.
- Hold out_ready = 0 with a result pending and present a second frame → in_ready = 0, out_data unchanged. Raise out_ready → second frame proceeds with no lost beats.
- Continuous single-beat frames with out_ready = 1 → one result per cycle, each equal to that beat's input, in_ready constantly 1.
- Beat with in_first = 0 after reset, then in_first = 1 mid-frame → proto_err = 1 and stays set. The second frame's result excludes earlier beats.
- Assert rst_n low mid-frame with out_valid = 1 → all outputs return to reset values asynchronously. The next frame's sum starts from 0.
